// File: rtl/dmem_responder.sv
// dmem_responder: 1024 x 32 (by default) data memory responder for the MIPS
// memory stage. Loads and stores are accepted from IDLE, stall the CPU via
// MemBusyM and finish with a one-cycle RESP carrying ReadDataM / MemErrM.
// Optional feature macro: DMEM_WAIT_EN adds a WAIT state of WAIT_CYCLES edges
// between capture and response; without it IDLE goes straight to RESP.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] EXResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemBusyM,
  output logic        MemErrM
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

`ifdef DMEM_WAIT_EN
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd2} state_t;
`endif

  function automatic logic is_load_op(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load_op = 1'b1;
      default:                             is_load_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_store_op(input logic [5:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: is_store_op = 1'b1;
      default:             is_store_op = 1'b0;
    endcase
  endfunction

  // Halfwords must be 2-byte aligned, words 4-byte aligned.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: is_misaligned = lo[0];
      OP_LW, OP_SW:         is_misaligned = (lo != 2'd0);
      default:              is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_lanes(input logic [5:0] op, input logic [1:0] lo);
    case (op)
      OP_SB:   store_lanes = 4'b0001 << lo;
      OP_SH:   store_lanes = lo[1] ? 4'b1100 : 4'b0011;
      OP_SW:   store_lanes = 4'b1111;
      default: store_lanes = 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data across lanes; the lane mask picks one copy.
  function automatic logic [31:0] store_data(input logic [5:0] op, input logic [31:0] wd);
    case (op)
      OP_SB:   store_data = {4{wd[7:0]}};
      OP_SH:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [5:0] op, input logic [1:0] lo,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   load_extract = {{24{b[7]}}, b};
      OP_LBU:  load_extract = {24'd0, b};
      OP_LH:   load_extract = {{16{h[15]}}, h};
      OP_LHU:  load_extract = {16'd0, h};
      OP_LW:   load_extract = word;
      default: load_extract = 32'd0;
    endcase
  endfunction

  logic [31:0]       ram [DEPTH];
  state_t            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              load_q, load_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              merr_q, merr_d;
`ifdef DMEM_WAIT_EN
  logic [3:0]        cnt_q, cnt_d;
`endif

  logic              req_s;
  logic              acc_err_s;
  logic              wr_en_s;
  logic [3:0]        lanes_s;
  logic [31:0]       wr_data_s;
  logic [ADDR_W-1:0] in_idx_s;
  logic [ADDR_W-1:0] rd_idx_s;
  logic [31:0]       rd_word_s;
  logic              unused_s;

  // An access is erroneous when both strobes are high, the op does not match
  // the strobe (load op for reads, store op for writes) or it is misaligned.
  assign req_s     = MemReadM | MemWriteM;
  assign acc_err_s = (MemReadM & MemWriteM)
                   | (MemReadM & ~is_load_op(opM))
                   | (MemWriteM & ~is_store_op(opM))
                   | is_misaligned(opM, EXResultM[1:0]);
  assign in_idx_s  = EXResultM[ADDR_W+1:2];
  assign lanes_s   = store_lanes(opM, EXResultM[1:0]);
  assign wr_data_s = store_data(opM, WriteDataM);
  // Stores commit on the capture edge, so a following load sees the new data.
  assign wr_en_s   = (state_q == IDLE) & MemWriteM & ~acc_err_s & rst;

`ifdef DMEM_WAIT_EN
  assign rd_idx_s  = addr_q[ADDR_W+1:2];
  assign MemBusyM  = ((state_q == IDLE) & req_s) | (state_q == WAIT);
  assign unused_s  = ^{wdata_q, addr_q[31:ADDR_W+2], EXResultM[31:ADDR_W+2]};
`else
  assign rd_idx_s  = in_idx_s;
  assign MemBusyM  = (state_q == IDLE) & req_s;
  assign unused_s  = ^{op_q, addr_q, wdata_q, load_q, err_q, EXResultM[31:ADDR_W+2],
                       4'(WAIT_CYCLES)};
`endif

  assign rd_word_s = ram[rd_idx_s];
  assign ReadDataM = rdata_q;
  assign MemErrM   = merr_q;

  // Byte-lane RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en_s && lanes_s[i]) begin
        ram[in_idx_s][8*i +: 8] <= wr_data_s[8*i +: 8];
      end
    end
  end

  // State, capture and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= 6'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      merr_q  <= 1'b0;
`ifdef DMEM_WAIT_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      merr_q  <= merr_d;
`ifdef DMEM_WAIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state logic; response data/error are loaded only on the edge into RESP.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    load_d  = load_q;
    err_d   = err_q;
    rdata_d = 32'd0;
    merr_d  = 1'b0;
`ifdef DMEM_WAIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_s) begin
          op_d    = opM;
          addr_d  = EXResultM;
          wdata_d = WriteDataM;
          load_d  = MemReadM & ~MemWriteM;
          err_d   = acc_err_s;
`ifdef DMEM_WAIT_EN
          state_d = WAIT;
          cnt_d   = 4'd0;
`else
          state_d = RESP;
          merr_d  = acc_err_s;
          rdata_d = (MemReadM && !acc_err_s) ?
                    load_extract(opM, EXResultM[1:0], rd_word_s) : 32'd0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
`ifdef DMEM_WAIT_EN
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = RESP;
          merr_d  = err_q;
          rdata_d = (load_q && !err_q) ? load_extract(op_q, addr_q[1:0], rd_word_s) : 32'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus randomized
// accesses checked against a byte-addressed memory model.
module tb_dmem_responder;
  localparam int ADDR_W      = 10;
  localparam int WAIT_CYCLES = 2;
  localparam int NBYTES      = 4 << ADDR_W;
`ifdef DMEM_WAIT_EN
  localparam int EXP_BUSY = 1 + WAIT_CYCLES;
`else
  localparam int EXP_BUSY = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opM;
  logic        MemReadM, MemWriteM;
  logic [31:0] EXResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        MemBusyM, MemErrM;

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst(rst), .opM(opM), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .EXResultM(EXResultM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
    .MemBusyM(MemBusyM), .MemErrM(MemErrM));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mb [NBYTES];
  logic [31:0] got_data;
  logic        got_err;
  int          got_busy;

  typedef struct {
    logic [5:0]  op;
    logic        rd, wr;
    logic [31:0] a, wd, ed;
    logic        ee;
  } vec_t;
  vec_t dq[$];

  logic [5:0] pool [12] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
                            6'h3F, 6'h00, 6'h22, 6'h2A};

  task automatic drive(input logic [5:0] op, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd);
    opM = op; MemReadM = rd; MemWriteM = wr; EXResultM = a; WriteDataM = wd;
  endtask

  task automatic drive_idle();
    drive(6'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Count stall cycles of the currently driven access and sample its RESP cycle.
  task automatic run_access(input bit chain);
    bit done = 1'b0;
    if (chain) @(negedge clk);
    got_busy = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (MemBusyM === 1'b1) begin got_busy++; @(negedge clk); end
      else done = 1'b1;
    end
    got_data = ReadDataM;
    got_err  = MemErrM;
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL access_timeout: busy for %0d cycles, required release within 40", got_busy);
    end
  endtask

  function automatic int op_size(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28: return 1;
      6'h21, 6'h25, 6'h29: return 2;
      6'h23, 6'h2B:        return 4;
      default:             return 0;
    endcase
  endfunction

  // Reference: little-endian byte memory, address taken modulo its size.
  task automatic model(input logic [5:0] op, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] ed, output logic ee);
    int          sz   = op_size(op);
    bit          ld   = (sz > 0) && (op < 6'h28);
    bit          st   = (sz > 0) && (op >= 6'h28);
    int unsigned base = a % NBYTES;
    longint      v    = 0;
    ed = 32'd0;
    ee = (rd && wr) || (rd && !ld) || (wr && !st) || (sz != 0 && (a % sz) != 0);
    if (!ee && wr)
      for (int i = 0; i < sz; i++) mb[base + i] = wd[8*i +: 8];
    if (!ee && rd) begin
      for (int i = 0; i < sz; i++) v += longint'(mb[base + i]) << (8*i);
      if ((op == 6'h20 || op == 6'h21) && v >= (longint'(1) << (8*sz - 1)))
        v -= longint'(1) << (8*sz);
      ed = v[31:0];
    end
  endtask

  task automatic add_vec(input logic [5:0] op, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] ed, input logic ee);
    vec_t e;
    e.op = op; e.rd = rd; e.wr = wr; e.a = a; e.wd = wd; e.ed = ed; e.ee = ee;
    dq.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (ReadDataM !== 32'd0) begin n_bad++; $display("FAIL reset_rdata: got %h want %h", ReadDataM, 32'd0); end
    n_cmp++; if (MemErrM !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", MemErrM); end
    n_cmp++; if (MemBusyM !== 1'b0) begin n_bad++; $display("FAIL reset_busy_idle: got %b want 0", MemBusyM); end
    drive(6'h23, 1'b1, 1'b0, 32'h10, 32'd0);
    #1;
    n_cmp++; if (MemBusyM !== 1'b1) begin n_bad++; $display("FAIL reset_busy_req: got %b want 1", MemBusyM); end
    drive_idle();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  // Fill the 64-word test region with random words so every later load is defined.
  task automatic test_init();
    logic [31:0] ed, wd;
    logic        ee;
    for (int w = 0; w < 64; w++) begin
      wd = $urandom;
      drive(6'h2B, 1'b0, 1'b1, 32'(w * 4), wd);
      model(6'h2B, 1'b0, 1'b1, 32'(w * 4), wd, ed, ee);
      run_access(1'b0);
      n_cmp++; if (got_err !== 1'b0) begin n_bad++; $display("FAIL init_err w%0d: got %b want 0", w, got_err); end
      n_cmp++; if (got_busy != EXP_BUSY) begin n_bad++; $display("FAIL init_busy w%0d: got %0d want %0d", w, got_busy, EXP_BUSY); end
      drive_idle();
      @(negedge clk);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ed;
    logic        ee;
    add_vec(6'h2B, 1'b0, 1'b1, 32'h10,   32'h12345678, 32'h0,        1'b0);
    add_vec(6'h23, 1'b1, 1'b0, 32'h10,   32'h0,        32'h12345678, 1'b0);
    add_vec(6'h2B, 1'b0, 1'b1, 32'h10,   32'h0,        32'h0,        1'b0);
    add_vec(6'h28, 1'b0, 1'b1, 32'h13,   32'h000000F0, 32'h0,        1'b0);
    add_vec(6'h20, 1'b1, 1'b0, 32'h13,   32'h0,        32'hFFFFFFF0, 1'b0);
    add_vec(6'h24, 1'b1, 1'b0, 32'h13,   32'h0,        32'h000000F0, 1'b0);
    add_vec(6'h23, 1'b1, 1'b0, 32'h10,   32'h0,        32'hF0000000, 1'b0);
    add_vec(6'h29, 1'b0, 1'b1, 32'h22,   32'h00008001, 32'h0,        1'b0);
    add_vec(6'h21, 1'b1, 1'b0, 32'h22,   32'h0,        32'hFFFF8001, 1'b0);
    add_vec(6'h25, 1'b1, 1'b0, 32'h22,   32'h0,        32'h00008001, 1'b0);
    add_vec(6'h2B, 1'b0, 1'b1, 32'h1000, 32'hAAAA5555, 32'h0,        1'b0);
    add_vec(6'h23, 1'b1, 1'b0, 32'h0,    32'h0,        32'hAAAA5555, 1'b0);
    add_vec(6'h23, 1'b1, 1'b0, 32'h11,   32'h0,        32'h0,        1'b1);
    add_vec(6'h29, 1'b0, 1'b1, 32'h23,   32'h00001234, 32'h0,        1'b1);
    add_vec(6'h3F, 1'b1, 1'b0, 32'h10,   32'h0,        32'h0,        1'b1);
    add_vec(6'h23, 1'b1, 1'b0, 32'h10,   32'h0,        32'hF0000000, 1'b0);
    add_vec(6'h25, 1'b1, 1'b0, 32'h22,   32'h0,        32'h00008001, 1'b0);
    add_vec(6'h2B, 1'b1, 1'b1, 32'h10,   32'hDEADBEEF, 32'h0,        1'b1);
    add_vec(6'h23, 1'b1, 1'b0, 32'h10,   32'h0,        32'hF0000000, 1'b0);
    foreach (dq[i]) begin
      drive(dq[i].op, dq[i].rd, dq[i].wr, dq[i].a, dq[i].wd);
      model(dq[i].op, dq[i].rd, dq[i].wr, dq[i].a, dq[i].wd, ed, ee);
      run_access(1'b0);
      n_cmp++; if (got_data !== dq[i].ed) begin n_bad++; $display("FAIL dir_data[%0d]: got %h want %h", i, got_data, dq[i].ed); end
      n_cmp++; if (got_err !== dq[i].ee) begin n_bad++; $display("FAIL dir_err[%0d]: got %b want %b", i, got_err, dq[i].ee); end
      n_cmp++; if (got_busy != EXP_BUSY) begin n_bad++; $display("FAIL dir_busy[%0d]: got %0d want %0d", i, got_busy, EXP_BUSY); end
      drive_idle();
      @(negedge clk); #1;
      n_cmp++; if (ReadDataM !== 32'd0 || MemErrM !== 1'b0) begin n_bad++; $display("FAIL dir_after_resp[%0d]: got data %h err %b want 0/0", i, ReadDataM, MemErrM); end
    end
  endtask

  // Store immediately followed by a load of the same word.
  task automatic test_back_to_back();
    logic [31:0] ed, wd, a;
    logic        ee;
    for (int k = 0; k < 8; k++) begin
      a  = 32'($urandom_range(63) * 4);
      wd = $urandom;
      drive(6'h2B, 1'b0, 1'b1, a, wd);
      model(6'h2B, 1'b0, 1'b1, a, wd, ed, ee);
      run_access(1'b0);
      n_cmp++; if (got_err !== 1'b0) begin n_bad++; $display("FAIL b2b_store_err[%0d]: got %b want 0", k, got_err); end
      drive(6'h23, 1'b1, 1'b0, a, 32'd0);
      run_access(1'b1);
      n_cmp++; if (got_data !== wd) begin n_bad++; $display("FAIL b2b_load[%0d]: got %h want %h", k, got_data, wd); end
      n_cmp++; if (got_busy != EXP_BUSY) begin n_bad++; $display("FAIL b2b_busy[%0d]: got %0d want %0d", k, got_busy, EXP_BUSY); end
      drive_idle();
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [31:0] ed, wd, a;
    logic [5:0]  op;
    logic        ee, rd, wr;
    bit          chain = 1'b0;
    for (int k = 0; k < 300; k++) begin
      op = pool[$urandom_range(11)];
      if ($urandom_range(9) == 0) begin
        rd = 1'($urandom_range(1)); wr = ~rd | 1'($urandom_range(1));
      end else begin
        rd = (op < 6'h28); wr = ~rd;
      end
      a = 32'($urandom_range(63) * 4 + $urandom_range(3));
      if ($urandom_range(3) == 0) a = a | ($urandom << 12);
      wd = $urandom;
      drive(op, rd, wr, a, wd);
      model(op, rd, wr, a, wd, ed, ee);
      run_access(chain);
      n_cmp++; if (got_data !== ed) begin n_bad++; $display("FAIL rnd_data[%0d] op %h a %h: got %h want %h", k, op, a, got_data, ed); end
      n_cmp++; if (got_err !== ee) begin n_bad++; $display("FAIL rnd_err[%0d] op %h a %h: got %b want %b", k, op, a, got_err, ee); end
      n_cmp++; if (got_busy != EXP_BUSY) begin n_bad++; $display("FAIL rnd_busy[%0d]: got %0d want %0d", k, got_busy, EXP_BUSY); end
      chain = 1'($urandom_range(1));
      if (!chain) begin
        drive_idle();
        @(negedge clk); #1;
        n_cmp++; if (ReadDataM !== 32'd0 || MemErrM !== 1'b0 || MemBusyM !== 1'b0) begin n_bad++; $display("FAIL rnd_idle[%0d]: got data %h err %b busy %b want 0/0/0", k, ReadDataM, MemErrM, MemBusyM); end
      end
    end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] ed;
    logic        ee;
    // Store interrupted right after its commit edge.
    drive(6'h2B, 1'b0, 1'b1, 32'h30, 32'h5A5AC3C3);
    model(6'h2B, 1'b0, 1'b1, 32'h30, 32'h5A5AC3C3, ed, ee);
    @(negedge clk); drive_idle(); rst = 1'b0; #1;
    n_cmp++; if (MemBusyM !== 1'b0 || ReadDataM !== 32'd0 || MemErrM !== 1'b0) begin n_bad++; $display("FAIL rstmid_store: got busy %b data %h err %b want 0/0/0", MemBusyM, ReadDataM, MemErrM); end
    @(negedge clk); rst = 1'b1;
    // Load interrupted in its first stall cycle after capture.
    drive(6'h23, 1'b1, 1'b0, 32'h10, 32'd0);
    @(negedge clk); drive_idle(); rst = 1'b0; #1;
    n_cmp++; if (MemBusyM !== 1'b0 || ReadDataM !== 32'd0 || MemErrM !== 1'b0) begin n_bad++; $display("FAIL rstmid_load: got busy %b data %h err %b want 0/0/0", MemBusyM, ReadDataM, MemErrM); end
    @(negedge clk); #1;
    n_cmp++; if (MemBusyM !== 1'b0 || ReadDataM !== 32'd0 || MemErrM !== 1'b0) begin n_bad++; $display("FAIL rstmid_next: got busy %b data %h err %b want 0/0/0", MemBusyM, ReadDataM, MemErrM); end
    rst = 1'b1;
    @(negedge clk);
    drive(6'h23, 1'b1, 1'b0, 32'h30, 32'd0);
    run_access(1'b0);
    n_cmp++; if (got_data !== 32'h5A5AC3C3) begin n_bad++; $display("FAIL rstmid_kept: got %h want %h", got_data, 32'h5A5AC3C3); end
    drive_idle(); @(negedge clk);
    model(6'h23, 1'b1, 1'b0, 32'h10, 32'd0, ed, ee);
    drive(6'h23, 1'b1, 1'b0, 32'h10, 32'd0);
    run_access(1'b0);
    n_cmp++; if (got_data !== ed || got_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_after: got %h/%b want %h/0", got_data, got_err, ed); end
    drive_idle(); @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the internal RAM (1024 x 32 bits).
REQ-002 Parameter WAIT_CYCLES, default 2, wait states per access when DMEM_WAIT_EN is defined; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 opM  input  6  MIPS opcode of the memory-stage instruction.
REQ-006 MemReadM  input  1  load request.
REQ-007 MemWriteM  input  1  store request.
REQ-008 EXResultM  input  32  byte address.
REQ-009 WriteDataM  input  32  store data, right-aligned.
REQ-010 ReadDataM  output  32  load result, extended to 32 bits.
REQ-011 MemBusyM  output  1  stall request to the CPU hazard logic.
REQ-012 MemErrM  output  1  one-cycle pulse marking a misaligned or unsupported access.

Function
REQ-013 A request exists when MemReadM|MemWriteM is 1; both high at once is an unsupported access.
REQ-014 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-015 MemBusyM SHALL equal (IDLE and request) or WAIT, combinationally; it SHALL be 0 in RESP.
REQ-016 In IDLE with a request, the clock edge SHALL capture op, address, data and type, then move to WAIT (macro on) or RESP (macro off).
REQ-017 WAIT SHALL count WAIT_CYCLES edges with a 4-bit counter, then move to RESP; the counter SHALL clear on entry.
REQ-018 RESP SHALL last exactly one cycle, then move to IDLE; a new request is accepted only from IDLE.
REQ-019 Supported ops: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B; any other op with a request is unsupported.
REQ-020 RAM index = address[ADDR_W+1:2]; upper address bits SHALL be ignored (wrap-around).
REQ-021 A store SHALL commit on the capture edge, using byte lanes selected by address[1:0] (sb: one lane, sh: lanes 1:0 or 3:2, sw: all four).
REQ-022 A load SHALL register the selected RAM word on the last edge before RESP.
REQ-023 During RESP, ReadDataM SHALL present the addressed byte/half, sign-extended (lb, lh) or zero-extended (lbu, lhu).
REQ-024 Outside RESP, and for stores, ReadDataM SHALL be 0.
REQ-025 Misalignment is a halfword access with address[0]=1 or a word access with address[1:0]!=0.
REQ-026 A misaligned or unsupported access SHALL write nothing, return ReadDataM=0, and assert MemErrM for the RESP cycle only.
REQ-027 A load issued directly after a store to the same word SHALL return the stored data; there is no bypass hazard because the store has already committed.
REQ-028 Overall latency SHALL be 1 + WAIT_CYCLES stall cycles (macro on) or 1 stall cycle (macro off) per access.

Reset
REQ-029 While rst=0: state=IDLE, counter=0, captured registers=0, ReadDataM=0, MemErrM=0; MemBusyM follows REQ-015.
REQ-030 Reset mid-access SHALL abandon the access immediately; a store already committed SHALL remain in RAM.
REQ-031 RAM contents SHALL NOT be reset.

Configuration
REQ-032 DMEM_WAIT_EN defined: the WAIT state and counter exist and WAIT_CYCLES applies.
REQ-033 DMEM_WAIT_EN undefined: the WAIT state and counter are removed, IDLE goes directly to RESP, and WAIT_CYCLES is ignored.

Verification
REQ-034 sw 0x12345678 to address 0x10, then lw from 0x10 -> ReadDataM=0x12345678 in RESP; MemBusyM high for 3 cycles (macro on, WAIT_CYCLES=2) or 1 cycle (macro off).
REQ-035 sb 0x000000F0 to address 0x13 over word 0x00000000; lb 0x13 -> 0xFFFFFFF0; lbu 0x13 -> 0x000000F0; lw 0x10 -> 0xF0000000.
REQ-036 sh 0x8001 to address 0x22; lh 0x22 -> 0xFFFF8001; lhu 0x22 -> 0x00008001.
REQ-037 lw at 0x11, sh at 0x23, and op 0x3F with MemReadM=1 -> MemErrM one-cycle pulse each, ReadDataM=0, RAM unchanged.
REQ-038 sw 0xAAAA5555 to address 0x1000 (ADDR_W=10), then lw 0x0 -> 0xAAAA5555 (wrap-around).
REQ-039 rst low during WAIT of a lw -> next cycle state=IDLE, MemBusyM=0 with no request present, ReadDataM=0, MemErrM=0.
